// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-bus definitions: default widths, latencies and mask encodings.
package mem_bus_defs;

  localparam int MEM_AW         = 32;
  localparam int MEM_DW         = 32;
  localparam int MEM_MASK_W     = MEM_DW / 8;
  // Memory returns read data the cycle after mem_rstb_o.
  localparam int MEM_RD_LATENCY = 1;
  // Secondary read response arrives two cycles after its grant.
  localparam int RESP_LATENCY   = 2;

  // Byte-mask encodings: all-zero means "no write", all-ones is a full word.
  localparam logic [MEM_MASK_W-1:0] MASK_NONE = '0;
  localparam logic [MEM_MASK_W-1:0] MASK_ALL  = '1;

endpackage

// File: rtl/mem_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// cnt_nxt_o is the value the register takes at the next edge, so a consumer can
// register a threshold flag that stays in step with the count.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_nxt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Next count: clear wins, otherwise step up unless already at the ceiling.
  always_comb begin
    cnt_nxt_o = cnt_q;
    if (clr_i) begin
      cnt_nxt_o = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_nxt_o = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt_o;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: the core owns every cycle it uses with no added latency; a
// secondary master (DMA / debug loader) fills the idle cycles through a valid/ready
// port. Secondary reads return two cycles after the grant; starvation is flagged.
//
// Handshake: a secondary request transfers in a cycle where s_valid_i and s_ready_o
// are both high. s_ready_o depends only on s_valid_i and the core strobes of the same
// cycle; the master holds valid and payload stable until it sees ready.
module mem_bus_arbiter
  import mem_bus_defs::*;
#(
  parameter int AW           = MEM_AW,
  parameter int DW           = MEM_DW,
  parameter int CNT_W        = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // core port
  input  logic [AW-1:0]   c_addr_i,
  input  logic            c_rstb_i,
  input  logic [DW-1:0]   c_wdata_i,
  input  logic [DW/8-1:0] c_mask_i,
  output logic [DW-1:0]   c_rdata_o,
  // secondary port
  input  logic            s_valid_i,
  output logic            s_ready_o,
  input  logic            s_we_i,
  input  logic [AW-1:0]   s_addr_i,
  input  logic [DW-1:0]   s_wdata_i,
  input  logic [DW/8-1:0] s_mask_i,
  output logic            s_rvalid_o,
  output logic [DW-1:0]   s_rdata_o,
  output logic            s_starve_o,
  // shared memory bus
  output logic [AW-1:0]   mem_addr_o,
  output logic            mem_rstb_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_mask_o,
  input  logic [DW-1:0]   mem_rdata_i
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                    core_act;
  logic                    grant;
  logic [RESP_LATENCY-1:0] rd_pend;
  logic [CNT_W-1:0]        wait_cnt_nxt;

  assign core_act  = c_rstb_i | (|c_mask_i);
  assign s_ready_o = s_valid_i & ~core_act;
  assign grant     = s_valid_i & s_ready_o;
  assign c_rdata_o = mem_rdata_i;

  // Bus mux: core has absolute priority, secondary only in free cycles.
  always_comb begin
    mem_addr_o  = c_addr_i;
    mem_rstb_o  = 1'b0;
    mem_wdata_o = c_wdata_i;
    mem_mask_o  = '0;
    if (core_act) begin
      mem_rstb_o = c_rstb_i;
      mem_mask_o = c_mask_i;
    end else if (grant) begin
      mem_addr_o  = s_addr_i;
      mem_rstb_o  = ~s_we_i;
      mem_wdata_o = s_wdata_i;
      // A zero-mask write leaves the bus idle: accepted as a no-op.
      mem_mask_o  = s_we_i ? s_mask_i : '0;
    end
  end

  // Secondary read pipeline: capture memory data one cycle after grant, flag it next.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend   <= '0;
      s_rdata_o <= '0;
    end else begin
      rd_pend <= {rd_pend[0], grant & ~s_we_i};
      if (rd_pend[0]) begin
        s_rdata_o <= mem_rdata_i;
      end
    end
  end

  assign s_rvalid_o = rd_pend[1];

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (grant | ~s_valid_i),
    .inc_i     (s_valid_i & ~s_ready_o),
    .cnt_nxt_o (wait_cnt_nxt)
  );

  // Starvation flag tracks the registered wait count, so it drops the cycle after a grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_starve_o <= 1'b0;
    end else begin
      s_starve_o <= (wait_cnt_nxt >= LIMIT);
    end
  end

endmodule
